// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 LCD controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } lcd_state_e;

    // Power-up init sequence (all RS=0): function set, display on, clear, entry mode
    localparam int         INIT_CNT  = 4;
    localparam logic [1:0] INIT_LAST = 2'(INIT_CNT - 1);

    // Store-data word fields
    localparam int D_ON      = 31;
    localparam int D_CLR_OVF = 30;
    localparam int D_RS      = 8;

    // Status word fields
    localparam int ST_BUSY = 0;
    localparam int ST_PEND = 1;
    localparam int ST_OVF  = 2;
    localparam int ST_INIT = 3;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// Turns LSU stores to the LCD register into timed HD44780 write cycles,
// runs the power-up init sequence and buffers one command while busy.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned PWRUP_CYC = 750000,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 25,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned EXEC_CYC  = 2500,
    parameter int unsigned CLEAR_CYC = 82000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lcd_wr_i,
    input  logic [31:0] lcd_data_i,
    output logic [31:0] lcd_status_o,
    output logic        lcd_on_o,
    output logic        lcd_blon_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic [7:0]  lcd_data_o
);

    // Counter load value for an N-cycle state; N=0 behaves as 1
    function automatic logic [CNT_W-1:0] ld(input int unsigned n);
        return (n == 0) ? '0 : CNT_W'(n - 1);
    endfunction

    localparam logic [CNT_W-1:0] PWRUP_LD = ld(PWRUP_CYC);
    localparam logic [CNT_W-1:0] SETUP_LD = ld(SETUP_CYC);
    localparam logic [CNT_W-1:0] PULSE_LD = ld(PULSE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD  = ld(HOLD_CYC);
    localparam logic [CNT_W-1:0] EXEC_LD  = ld(EXEC_CYC);
    localparam logic [CNT_W-1:0] CLEAR_LD = ld(CLEAR_CYC);

    lcd_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       init_idx_q;
    logic             init_done_q;
    logic             busy_q;
    logic             pend_q;
    logic             pend_rs_q;
    logic [7:0]       pend_byte_q;
    logic             ovf_q;

    logic is_clr_wr;
    logic is_cmd_wr;
    logic long_wait;
    logic cnt_zero;

    assign is_clr_wr = lcd_wr_i &  lcd_data_i[D_CLR_OVF];
    assign is_cmd_wr = lcd_wr_i & ~lcd_data_i[D_CLR_OVF];
    // Clear and home need the long execution wait
    assign long_wait = ~lcd_rs_o & ((lcd_data_o == 8'h01) || (lcd_data_o == 8'h02));
    assign cnt_zero  = (cnt_q == '0);

    // Data-word bits that have no meaning for this register
    logic unused_data;
    assign unused_data = ^lcd_data_i[29:9];

    // Sequencer: state, delay counter, pending buffer, status flags and pins
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_PWRUP;
            cnt_q       <= '0;
            init_idx_q  <= '0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
            pend_q      <= 1'b0;
            pend_rs_q   <= 1'b0;
            pend_byte_q <= '0;
            ovf_q       <= 1'b0;
            lcd_on_o    <= 1'b0;
            lcd_rs_o    <= 1'b0;
            lcd_en_o    <= 1'b0;
            lcd_data_o  <= '0;
        end else begin
            if (lcd_wr_i) lcd_on_o <= lcd_data_i[D_ON];
            if (is_clr_wr) ovf_q <= 1'b0;

            // A command arriving while busy is queued or dropped; the S_WAIT
            // branch below overrides this when it consumes the write directly
            if (is_cmd_wr && state_q != S_IDLE) begin
                if (!pend_q) begin
                    pend_q      <= 1'b1;
                    pend_rs_q   <= lcd_data_i[D_RS];
                    pend_byte_q <= lcd_data_i[7:0];
                end else begin
                    ovf_q <= 1'b1;
                end
            end

            case (state_q)
                S_PWRUP: begin
                    // Counts up from the reset value so reset needs no preload
                    if (cnt_q == PWRUP_LD) begin
                        state_q    <= S_SETUP;
                        cnt_q      <= SETUP_LD;
                        init_idx_q <= '0;
                        lcd_rs_o   <= 1'b0;
                        lcd_data_o <= init_cmd(2'd0);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    if (is_cmd_wr) begin
                        state_q    <= S_SETUP;
                        cnt_q      <= SETUP_LD;
                        busy_q     <= 1'b1;
                        lcd_rs_o   <= lcd_data_i[D_RS];
                        lcd_data_o <= lcd_data_i[7:0];
                    end
                end
                S_SETUP: begin
                    if (cnt_zero) begin
                        state_q  <= S_PULSE;
                        cnt_q    <= PULSE_LD;
                        lcd_en_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_PULSE: begin
                    if (cnt_zero) begin
                        state_q  <= S_HOLD;
                        cnt_q    <= HOLD_LD;
                        lcd_en_o <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt_zero) begin
                        state_q <= S_WAIT;
                        cnt_q   <= long_wait ? CLEAR_LD : EXEC_LD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (!init_done_q && init_idx_q != INIT_LAST) begin
                        state_q    <= S_SETUP;
                        cnt_q      <= SETUP_LD;
                        init_idx_q <= init_idx_q + 2'd1;
                        lcd_rs_o   <= 1'b0;
                        lcd_data_o <= init_cmd(init_idx_q + 2'd1);
                    end else begin
                        init_done_q <= 1'b1;
                        if (pend_q) begin
                            state_q    <= S_SETUP;
                            cnt_q      <= SETUP_LD;
                            pend_q     <= 1'b0;
                            lcd_rs_o   <= pend_rs_q;
                            lcd_data_o <= pend_byte_q;
                        end else if (is_cmd_wr) begin
                            state_q    <= S_SETUP;
                            cnt_q      <= SETUP_LD;
                            pend_q     <= 1'b0;
                            lcd_rs_o   <= lcd_data_i[D_RS];
                            lcd_data_o <= lcd_data_i[7:0];
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= S_PWRUP;
                    cnt_q    <= '0;
                    lcd_en_o <= 1'b0;
                end
            endcase
        end
    end

    // Status word assembled from registered flags
    always_comb begin
        lcd_status_o          = '0;
        lcd_status_o[ST_BUSY] = busy_q;
        lcd_status_o[ST_PEND] = pend_q;
        lcd_status_o[ST_OVF]  = ovf_q;
        lcd_status_o[ST_INIT] = init_done_q;
    end

    assign lcd_blon_o = lcd_on_o;
    assign lcd_rw_o   = 1'b0;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters.
module tb_lcd_ctrl;

    logic        clk;
    logic        rst_ni;
    logic        lcd_wr_i;
    logic [31:0] lcd_data_i;
    logic [31:0] lcd_status_o;
    logic        lcd_on_o, lcd_blon_o, lcd_rs_o, lcd_rw_o, lcd_en_o;
    logic [7:0]  lcd_data_o;

    lcd_ctrl #(
        .PWRUP_CYC(10), .SETUP_CYC(1), .PULSE_CYC(2),
        .HOLD_CYC(1), .EXEC_CYC(4), .CLEAR_CYC(8), .CNT_W(20)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .lcd_wr_i(lcd_wr_i), .lcd_data_i(lcd_data_i),
        .lcd_status_o(lcd_status_o), .lcd_on_o(lcd_on_o), .lcd_blon_o(lcd_blon_o),
        .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o), .lcd_en_o(lcd_en_o),
        .lcd_data_o(lcd_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // cycle index: number of rising edges since reset release
    int cyc;
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // EN pulse log: byte, RS, starting cycle and width of each pulse
    logic [7:0] ev_data [32];
    logic       ev_rs   [32];
    int         ev_start[32];
    int         ev_width[32];
    int         n_ev = 0;
    logic       en_prev = 1'b0;

    always @(negedge clk) begin
        if (lcd_en_o && !en_prev && n_ev < 32) begin
            ev_data[n_ev]  = lcd_data_o;
            ev_rs[n_ev]    = lcd_rs_o;
            ev_start[n_ev] = cyc;
            ev_width[n_ev] = 1;
            n_ev = n_ev + 1;
        end else if (lcd_en_o && n_ev > 0) begin
            ev_width[n_ev-1] = ev_width[n_ev-1] + 1;
        end
        en_prev = lcd_en_o;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_until(input int c);
        int g;
        g = 0;
        while (cyc < c && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("sync_cycle", cyc, c);
    endtask

    logic [7:0] init_b  [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    int         init_st [4] = '{11, 19, 27, 39};

    task automatic check_init(input int base);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("init%0d_data", i),  ev_data[base+i],  init_b[i]);
            chk($sformatf("init%0d_rs", i),    ev_rs[base+i],    0);
            chk($sformatf("init%0d_start", i), ev_start[base+i], init_st[i]);
            chk($sformatf("init%0d_width", i), ev_width[base+i], 2);
        end
    endtask

    task automatic check_ev(input string tag, input int i, input logic [7:0] d,
                            input logic rs, input int st);
        chk({tag, "_data"},  ev_data[i],  d);
        chk({tag, "_rs"},    ev_rs[i],    rs);
        chk({tag, "_start"}, ev_start[i], st);
        chk({tag, "_width"}, ev_width[i], 2);
    endtask

    initial begin
        int n43;
        rst_ni     = 1'b0;
        lcd_wr_i   = 1'b0;
        lcd_data_i = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_status", lcd_status_o, 32'h1);
        chk("rst_pins", {lcd_on_o, lcd_blon_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_data_o},
            '0);
        rst_ni = 1'b1;

        // power-up init sequence
        wait_until(45);
        chk("init_busy", lcd_status_o, 32'h1);
        wait_until(46);
        chk("init_idle", lcd_status_o, 32'h8);
        chk("init_count", n_ev, 4);
        check_init(0);

        // data write 0x141 with ON
        lcd_wr_i = 1'b1; lcd_data_i = 32'h8000_0141;
        @(negedge clk); lcd_wr_i = 1'b0;
        chk("d_on", {lcd_on_o, lcd_blon_o}, 2'b11);
        chk("d_rs_data", {lcd_rs_o, lcd_data_o}, 9'h141);
        chk("d_en_low", lcd_en_o, 0);
        wait_until(54);
        chk("d_busy_end", lcd_status_o, 32'h9);
        wait_until(55);
        chk("d_idle", lcd_status_o, 32'h8);
        check_ev("d", 4, 8'h41, 1'b1, 48);

        // clear command: long wait
        lcd_wr_i = 1'b1; lcd_data_i = 32'h0000_0001;
        @(negedge clk); lcd_wr_i = 1'b0;
        chk("c_on_off", lcd_on_o, 0);
        wait_until(67);
        chk("c_busy_end", lcd_status_o, 32'h9);
        wait_until(68);
        chk("c_idle", lcd_status_o, 32'h8);
        check_ev("c", 5, 8'h01, 1'b0, 57);

        // back-to-back writes, third one overflows
        lcd_wr_i = 1'b1; lcd_data_i = 32'h0000_0141;
        @(negedge clk); lcd_data_i = 32'h0000_0142;
        chk("q_busy", lcd_status_o, 32'h9);
        @(negedge clk); lcd_data_i = 32'h8000_0143;
        chk("q_pend", lcd_status_o, 32'hB);
        @(negedge clk); lcd_wr_i = 1'b0;
        chk("q_ovf", lcd_status_o, 32'hF);
        chk("q_on_dropped", lcd_on_o, 1);
        wait_until(76);
        chk("q_pend_hold", lcd_status_o, 32'hF);
        wait_until(77);
        chk("q_issue", lcd_status_o, 32'hD);
        chk("q_issue_bus", {lcd_rs_o, lcd_data_o}, 9'h142);
        wait_until(85);
        chk("q_idle", lcd_status_o, 32'hC);
        check_ev("q1", 6, 8'h41, 1'b1, 70);
        check_ev("q2", 7, 8'h42, 1'b1, 78);

        // clear overflow: no command
        lcd_wr_i = 1'b1; lcd_data_i = 32'h4000_0000;
        @(negedge clk); lcd_wr_i = 1'b0;
        chk("clr_status", lcd_status_o, 32'h8);
        chk("clr_on", lcd_on_o, 0);
        wait_until(95);
        chk("clr_no_pulse", n_ev, 8);

        // reset during EN high
        lcd_wr_i = 1'b1; lcd_data_i = 32'h8000_0130;
        @(negedge clk); lcd_wr_i = 1'b0;
        @(negedge clk);
        chk("r_en_high", lcd_en_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("r_en_drop", lcd_en_o, 0);
        chk("r_status", lcd_status_o, 32'h1);
        chk("r_pins", {lcd_on_o, lcd_rs_o, lcd_data_o}, '0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        wait_until(46);
        chk("r_idle", lcd_status_o, 32'h8);
        chk("r_count", n_ev, 13);
        check_init(9);

        n43 = 0;
        for (int i = 0; i < n_ev; i++) if (ev_data[i] == 8'h43) n43++;
        chk("dropped_never_sent", n43, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Downstream consumer of the LSU's LCD I/O register.
- Converts each LSU store to the LCD address into a correctly timed HD44780 bus transaction (RS/DATA setup, EN pulse, hold, execution wait).
- Runs the power-up init sequence, buffers one command while busy, and returns a status word that the LSU load mux exposes.
- Sits between the LSU and the board LCD pins.

Parameters:
- PWRUP_CYC, 750000: cycles to wait after reset before init (15 ms @ 50 MHz).
- SETUP_CYC, 2: cycles RS/DATA are stable before EN rises.
- PULSE_CYC, 25: EN high width in cycles (500 ns).
- HOLD_CYC, 2: cycles RS/DATA are held after EN falls.
- EXEC_CYC, 2500: post-command wait for normal commands and data (50 us).
- CLEAR_CYC, 82000: post-command wait for clear (0x01) and home (0x02) with RS=0 (1.64 ms).
- CNT_W, 20: delay counter width; must hold the largest cycle parameter.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- lcd_wr_i  in  1  one-cycle strobe; LSU store to the LCD address
- lcd_data_i  in  32  store data: [31]=ON, [30]=clear overflow flag, [8]=RS, [7:0]=byte
- lcd_status_o  out  32  [0]=busy, [1]=pending full, [2]=overflow, [3]=init_done, [31:4]=0
- lcd_on_o  out  1  LCD power
- lcd_blon_o  out  1  backlight; always equals lcd_on_o
- lcd_rs_o  out  1  register select
- lcd_rw_o  out  1  read/write; tied to 0 (write only)
- lcd_en_o  out  1  enable strobe
- lcd_data_o  out  8  LCD data bus

Behaviour:
- Clock and reset: single clock domain clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: all pin outputs 0; status busy=1, pend=0, ovf=0, init_done=0; FSM in S_PWRUP with counter 0.
- Reset asserted mid-transaction aborts it: EN drops to 0 immediately and the init sequence restarts.
- All outputs are registered.
- States:
  - S_PWRUP: counts PWRUP_CYC cycles, then goes to S_SETUP with init command 0 loaded.
  - S_IDLE: waits for work.
  - S_SETUP: RS/DATA driven, EN=0, for SETUP_CYC cycles.
  - S_PULSE: EN=1 for PULSE_CYC cycles.
  - S_HOLD: EN=0, RS/DATA held, for HOLD_CYC cycles.
  - S_WAIT: EN=0 for CLEAR_CYC cycles if RS=0 and byte is 0x01 or 0x02, otherwise EXEC_CYC cycles.
- Init sequence, all RS=0: 0x38, 0x0C, 0x01, 0x06. The S_WAIT exit after 0x06 sets init_done=1 and then follows the normal S_WAIT exit rules.
- S_WAIT exit priority:
  1. Next init command, if init is incomplete.
  2. Pending entry: go to S_SETUP and clear pend on the same edge.
  3. lcd_wr_i this cycle: go to S_SETUP with that command.
  4. Otherwise go to S_IDLE.
- S_IDLE: lcd_wr_i sampled high moves to S_SETUP on that edge; RS/DATA are valid from that edge.
- Latency from the accepting edge: EN rises after SETUP_CYC cycles, stays high PULSE_CYC cycles, then HOLD_CYC + wait cycles follow before the next command may start.
- Write while busy (any state except S_IDLE):
  - pend=0: the command is stored in the one-entry pending buffer and pend=1.
  - pend=1: the command is dropped, ovf set to 1 (sticky), and the buffer is unchanged.
- Bit [31] (ON) of every write updates lcd_on_o/lcd_blon_o on the next edge, whether the command is accepted, queued, or dropped.
- A write with [30]=1 clears ovf and issues no command. If overflow and clear coincide, clear wins.
- busy=1 whenever the state is not S_IDLE.
- Counter rule: one down-counter loaded with (N-1) on state entry; advance when it reaches 0. Parameter N=0 is illegal and treated as 1.

Decomposition:
- lcd_pkg holds:
  - lcd_state_e enum (S_PWRUP, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT).
  - Init command ROM constants and init count (4).
  - Data-word bit positions (ON, CLR_OVF, RS) and status bit positions.
- No sub-module: the counter and FSM stay in one module. The LSU instantiates lcd_ctrl and routes lcd_status_o into its load mux at the LCD address.

Test Plan (PWRUP_CYC=10, SETUP_CYC=1, PULSE_CYC=2, HOLD_CYC=1, EXEC_CYC=4, CLEAR_CYC=8):
- Release reset, no writes -> after 10 cycles four EN pulses (2 cycles each) with DATA 0x38, 0x0C, 0x01, 0x06. Gap after 0x01 is 8 cycles, others 4. Then status = 0x8 (init_done, idle).
- After init, write 0x8000_0141 -> lcd_on_o=1 next edge; RS=1, DATA=0x41; EN high 1 cycle later for 2 cycles; busy=1 for 1+2+1+4 = 8 cycles, then status = 0x8.
- After init, write 0x0000_0001 -> EN pulse with RS=0, DATA=0x01; busy lasts 1+2+1+8 = 12 cycles.
- Two back-to-back writes 0x141, 0x142 -> 0x142 held pending (status[1]=1), then issued directly from S_WAIT with no S_IDLE cycle. A third write during the first command sets status[2]=1 and that byte never appears.
- Overflow set, write 0x4000_0000 -> status[2]=0 next cycle, no EN pulse.
- Assert rst_ni low while EN=1 -> EN=0 immediately, status = 0x1; after release, the full init sequence repeats.
